pll_reset_sequencer: RTL and testbench

- Sits beside the board PLL wrapper and runs on the free-running 50 MHz board reference clock.
- Issues the PLL reset, synchronises and debounces the PLL's asynchronous lock flag, and releases the system reset only after lock has been stable for a programmable time.
- On lock loss it re-resets the PLL and re-holds the system; a lock timeout forces a retry.
- sys_rst is a refclk-domain reset; consumers on the PLL output clock apply their own reset synchroniser.

---
 rtl/pll_seq_pkg.sv | 16 +
 rtl/pll_lock_sync.sv | 16 +
 rtl/pll_reset_sequencer.sv | 92 +++++++++
 tb/tb_pll_reset_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding, relock counter width and timer-width check for pll_reset_sequencer
package pll_seq_pkg;
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_e;
    localparam int RELOCK_W = 8;
    function automatic bit cnt_w_ok(input int cnt_w, input int a, input int b, input int c);
        longint m;
        m = longint'(a > b ? a : b);
        m = m > longint'(c) ? m : longint'(c);
        return a >= 1 && b >= 1 && c >= 1 && cnt_w >= 1 && cnt_w < 63 && (m - 64'sd1) < (64'sd1 <<< cnt_w);
    endfunction
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: STAGES-flop bit synchroniser; rst or clr forces every stage to 0
//   clk in, rst in (sync, active-high), clr in (sync clear), d in (async), q out (last stage)
module pll_lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;
    always_comb sync_d = (rst || clr) ? '0 : {sync_q[STAGES-2:0], d};
    always_ff @(posedge clk) sync_q <= sync_d;
    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset pulse, lock debounce and system reset release on refclk
//   refclk in, rst in (sync, active-high), pll_locked in (async)
//   pll_rst out, sys_rst out, ready out, timeout_flag out (sticky), relock_count[7:0] out
//   PLL_SEQ_RELOCK_CNT_EN builds the saturating relock counter; otherwise relock_count is 0
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_W               = 17
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                ready,
    output logic                timeout_flag,
    output logic [RELOCK_W-1:0] relock_count
);
    if (!cnt_w_ok(CNT_W, PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES) || SYNC_STAGES < 2) begin : g_bad_cfg
        $error("pll_reset_sequencer: CNT_W too narrow or SYNC_STAGES < 2");
    end
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             pll_rst_q, pll_rst_d, sys_rst_q, sys_rst_d, ready_q, ready_d, tmo_q, tmo_d;
    logic             locked_s;
    // pll_rst_q clears the synchroniser so a lock seen before the PLL reset cannot leak through
    pll_lock_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(refclk),
        .rst(rst),
        .clr(pll_rst_q),
        .d  (pll_locked),
        .q  (locked_s)
    );
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        case (state_q)
            PLL_RST:   state_d = timer_q == RST_LAST ? WAIT_LOCK : PLL_RST;
            WAIT_LOCK: begin
                state_d = locked_s ? STABLE : (timer_q == TMO_LAST ? PLL_RST : WAIT_LOCK);
                tmo_d   = tmo_q || (!locked_s && timer_q == TMO_LAST);
            end
            STABLE:    state_d = !locked_s ? WAIT_LOCK : (timer_q == STB_LAST ? RUN : STABLE);
            default:   state_d = locked_s ? RUN : PLL_RST;
        endcase
        timer_d   = state_d != state_q ? '0 : timer_q + 1'b1;
        pll_rst_d = state_d == PLL_RST;
        sys_rst_d = state_d != RUN;
        ready_d   = state_d == RUN;
    end
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= PLL_RST;
            timer_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            tmo_q     <= tmo_d;
        end
    end
`ifdef PLL_SEQ_RELOCK_CNT_EN
    logic                lock_lost;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    assign lock_lost = state_q == RUN && !locked_s;
    always_comb relock_d = (lock_lost && relock_q != '1) ? relock_q + 1'b1 : relock_q;
    always_ff @(posedge refclk) begin
        if (rst) relock_q <= '0;
        else relock_q <= relock_d;
    end
    assign relock_count = relock_q;
`else
    assign relock_count = '0;
`endif
    assign pll_rst      = pll_rst_q;
    assign sys_rst      = sys_rst_q;
    assign ready        = ready_q;
    assign timeout_flag = tmo_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed edge-accurate checks of reset release, lock, debounce, timeout and relock
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;
`ifdef PLL_SEQ_RELOCK_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic                refclk = 1'b0;
    logic                rst = 1'b1;
    logic                pll_locked = 1'b0;
    logic                pll_rst, sys_rst, ready, timeout_flag;
    logic [RELOCK_W-1:0] relock_count;
    int                  n_checks = 0;
    int                  n_fail = 0;
    int                  relocks = 0;
    pll_reset_sequencer #(
        .SYNC_STAGES(2),
        .PLL_RST_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32),
        .CNT_W(6)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .timeout_flag(timeout_flag),
        .relock_count(relock_count)
    );
    always #5 refclk = ~refclk;
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] exp_relock();
        return CNT_EN ? (relocks > 255 ? 32'd255 : 32'(relocks)) : 32'd0;
    endfunction
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
    initial begin
        repeat (3) tick();
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_tmo", timeout_flag, 0);
        check("rst_relock", relock_count, 0);
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check("rel_pll_rst", pll_rst, 32'(e < 4));
            check("rel_sys_rst", sys_rst, 1);
            check("rel_ready", ready, 0);
        end
        pll_locked = 1'b1;
        for (int e = 10; e <= 20; e++) begin
            tick();
            check("lock_sys_rst", sys_rst, 32'(e < 20));
            check("lock_ready", ready, 32'(e >= 20));
            check("lock_pll_rst", pll_rst, 0);
        end
        pll_locked = 1'b0;
        for (int e = 21; e <= 27; e++) begin
            tick();
            check("loss_sys_rst", sys_rst, 32'(e >= 23));
            check("loss_pll_rst", pll_rst, 32'(e >= 23 && e <= 26));
        end
        relocks = 1;
        check("loss_relock", relock_count, exp_relock());
        pll_locked = 1'b1;
        repeat (4) tick();
        check("deb_hold", sys_rst, 1);
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        for (int e = 35; e <= 45; e++) begin
            tick();
            check("deb_sys_rst", sys_rst, 32'(e < 45));
            check("deb_ready", ready, 32'(e >= 45));
        end
        pll_locked = 1'b0;
        for (int e = 46; e <= 95; e++) begin
            tick();
            check("tmo_pll_rst", pll_rst, 32'((e >= 48 && e <= 51) || (e >= 84 && e <= 87)));
            check("tmo_sys_rst", sys_rst, 32'(e >= 48));
            check("tmo_flag", timeout_flag, 32'(e >= 84));
        end
        relocks = 2;
        check("tmo_relock", relock_count, exp_relock());
        pll_locked = 1'b1;
        for (int e = 96; e <= 106; e++) begin
            tick();
            check("tmo_lock_sys_rst", sys_rst, 32'(e < 106));
        end
        check("tmo_lock_ready", ready, 1);
        check("tmo_sticky", timeout_flag, 1);
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            repeat (2) tick();
            check("rl_sys_hold", sys_rst, 0);
            tick();
            relocks++;
            check("rl_sys_rst", sys_rst, 1);
            check("rl_pll_rst_on", pll_rst, 1);
            check("rl_count", relock_count, exp_relock());
            pll_locked = 1'b1;
            repeat (3) tick();
            check("rl_pll_rst_hold", pll_rst, 1);
            tick();
            check("rl_pll_rst_off", pll_rst, 0);
            repeat (10) tick();
            check("rl_not_ready", ready, 0);
            tick();
            check("rl_ready", ready, 1);
        end
        check("rl_saturated", relock_count, CNT_EN ? 32'd255 : 32'd0);
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        repeat (8) tick();
        check("mid_stable_sys_rst", sys_rst, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_pll_rst", pll_rst, 1);
        check("mid_rst_sys_rst", sys_rst, 1);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_tmo", timeout_flag, 0);
        check("mid_rst_relock", relock_count, 0);
        repeat (3) tick();
        check("post_rst_pll_hold", pll_rst, 1);
        tick();
        check("post_rst_pll_off", pll_rst, 0);
        repeat (10) tick();
        check("post_rst_not_ready", ready, 0);
        tick();
        check("post_rst_ready", ready, 1);
        check("post_rst_tmo", timeout_flag, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
